// File: rtl/readout_pkg.sv
// Shared types and constants for the result readout path.
// SERIAL_PARITY_EN appends one even-parity bit to the readout stream.
package readout_pkg;

  localparam int RD_WORD_W    = 16;
  localparam int RD_NUM_WORDS = 3;
  // Address width shared with the scan-chain register map
  localparam int RD_ADDR_W    = 11;
  localparam int RD_DATA_LEN  = RD_WORD_W * RD_NUM_WORDS;
`ifdef SERIAL_PARITY_EN
  localparam int RD_STREAM_LEN = RD_DATA_LEN + 1;
`else
  localparam int RD_STREAM_LEN = RD_DATA_LEN;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_DONE
  } rtx_state_t;

endpackage

// File: rtl/serial_readout_tx_piso_shreg.sv
// Parallel-load, MSB-first shift register; load takes priority over shift.
module piso_shreg #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         dout
);

  logic [W-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[W-2:0], 1'b0};
    end
  end

  assign dout = q[W-1];

endmodule

// File: rtl/serial_readout_tx.sv
// Result readout serializer: one memory read per request, then MSB-first stream.
// Optional SERIAL_PARITY_EN appends an even-parity bit after the data bits.
module serial_readout_tx
  import readout_pkg::*;
#(
  parameter int WORD_W    = RD_WORD_W,
  parameter int NUM_WORDS = RD_NUM_WORDS,
  parameter int ADDR_W    = RD_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_external,
  input  logic [ADDR_W-1:0] read_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] rd_data0,
  input  logic [WORD_W-1:0] rd_data1,
  input  logic [WORD_W-1:0] rd_data2,
  output logic              serial_out,
  output logic              serial_valid,
  output logic              busy
);

  localparam int DATA_LEN = NUM_WORDS * WORD_W;
`ifdef SERIAL_PARITY_EN
  localparam int STREAM_LEN = DATA_LEN + 1;
`else
  localparam int STREAM_LEN = DATA_LEN;
`endif
  localparam int CNT_W = $clog2(STREAM_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STREAM_LEN - 1);

  rtx_state_t             state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   sh_load, sh_shift, sh_dout;
  logic [DATA_LEN-1:0]    fetch_word;
  logic [STREAM_LEN-1:0]  load_val;

  assign fetch_word = {rd_data0, rd_data1, rd_data2};
`ifdef SERIAL_PARITY_EN
  // Parity rides as the last shift-register bit so it leaves right after bit 0
  assign load_val = {fetch_word, ^fetch_word};
`else
  assign load_val = fetch_word;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = read_addr;
    case (state)
      ST_IDLE: begin
        rd_en = read_external;
        if (read_external) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (!read_external) begin
          state_nxt = ST_IDLE;
        end else begin
          sh_load   = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!read_external) begin
          state_nxt = ST_IDLE;
        end else begin
          sh_shift = 1'b1;
          if (cnt == '0) state_nxt = ST_DONE;
          else           cnt_nxt   = cnt - 1'b1;
        end
      end
      ST_DONE: begin
        // A fresh request needs read_external to fall first
        if (!read_external) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  piso_shreg #(.W(STREAM_LEN)) u_shreg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (load_val),
    .dout  (sh_dout)
  );

  // Stale register contents after an abort are masked outside SHIFT
  assign serial_valid = (state == ST_SHIFT);
  assign serial_out   = serial_valid & sh_dout;
  assign busy         = (state != ST_IDLE);

endmodule
